if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, issues instruction-memory requests, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of decode and takes the redirect produced downstream: the branch/jump target from the branch-target adder, resolved in the Memory stage. On a taken branch it redirects the PC and squashes the younger in-flight instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted for bubbles and flushes.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard-unit stall; hold PC and IF/ID.
- BranchTaken  input  1  MEM-stage branch/jump resolved taken.
- BranchTarget  input  32  target address from the branch-target adder, via EX/MEM.
- IMemReq  output  1  fetch request valid.
- IMemAddr  output  32  fetch address (equals PC).
- IMemReady  input  1  IMemData valid for IMemAddr this cycle.
- IMemData  input  32  instruction word.
- PC  output  32  current program counter.
- IF_ID_PCPlus4  output  32  PC+4 of the latched instruction.
- IF_ID_Instruction  output  32  latched instruction.
- IF_ID_Valid  output  1  latched instruction is real (not a bubble).
- FlushOut  output  1  squash ID/EX and EX/MEM at the next edge.

## Operation
- Reset (Reset_n low, asynchronous) sets the following values:
  - PC=RESET_PC, state=FETCH, skid buffer empty.
  - IF_ID_Instruction=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - IMemReq=0 and FlushOut=0 while reset is asserted.
- FSM states: FETCH, HOLD.
- FETCH: IMemReq=1, IMemAddr=PC.
  - IMemReady & !Stall: IF/ID <= {PC+4, IMemData, 1}; PC <= PC+4; stay in FETCH.
  - IMemReady & Stall: capture {PC+4, IMemData} in the skid buffer; PC <= PC+4; go to HOLD. IF/ID holds.
  - !IMemReady & !Stall: IF/ID <= {IF/ID PCPlus4 held, NOP_INSTR, 0} (bubble); PC holds.
  - !IMemReady & Stall: everything holds.
- HOLD: IMemReq=0, PC holds.
  - !Stall: IF/ID <= skid buffer with Valid=1; go to FETCH.
  - Stall: hold.
- BranchTaken has priority over Stall, IMemReady and state, in any state:
  - PC <= {BranchTarget[31:2], 2'b00}.
  - IF/ID <= {0, NOP_INSTR, 0}.
  - Skid buffer discarded; state <= FETCH.
  - IMemData in that cycle is ignored.
- FlushOut = BranchTaken & Reset_n, combinational, so ID/EX and EX/MEM clear on the same edge as the redirect.
- Arithmetic: PC+4 is 32-bit modulo (32'hFFFF_FFFC wraps to 0). PC[1:0] is always 00.

## Timing
- Memory is zero-wait when IMemReady is high in the same cycle: the instruction appears on the IF/ID outputs one edge after its address is presented.
- Sustained throughput is 1 instruction/cycle with IMemReady held high and no stall.
- Branch redirect:
  - BranchTarget is on IMemAddr in the cycle after the BranchTaken edge.
  - The target instruction is valid in IF/ID one cycle later.
  - Total penalty: 3 bubbles (IF, ID, EX squashed).
- Stall arriving on the same cycle as IMemReady: the fetched word is not lost; it is delivered from HOLD on the first non-stall cycle.
- Stall release from HOLD: IF/ID updates at that edge, and FETCH resumes at the new PC on the following cycle.
- Reset deasserted mid-operation: the first request at RESET_PC is issued in the first cycle after Reset_n rises.

## Structure
- Shared pipeline package holds:
  - RESET_PC and NOP_INSTR defaults.
  - FSM state encoding (FETCH=1'b0, HOLD=1'b1).
  - IF/ID field widths, which decode also uses.
- One sub-module: if_id_reg. It is the IF/ID register and takes load, clear and hold controls. The FSM and PC stay in if_stage.

## Test plan
- Reset then IMemReady=1 with a sequential word stream -> IMemAddr 0,4,8,...; IF_ID_Instruction matches each word one cycle later; IF_ID_PCPlus4 = 4,8,12; Valid=1.
- Stall for 3 cycles coinciding with IMemReady at PC=8 -> PC moves to 12 and then holds; IF/ID holds the PC=4 word; after release, IF/ID shows the PC=8 word and the next request is at 12.
- IMemReady low for 2 cycles at PC=16 -> two bubbles (Valid=0, NOP); PC stays at 16; fetch resumes normally.
- BranchTaken with BranchTarget=32'h0000_0103 while in HOLD with Stall=1 -> FlushOut=1 that cycle; next PC=32'h100; IF/ID Valid=0; skid word never delivered.
- PC=32'hFFFF_FFFC fetched -> IF_ID_PCPlus4=0 and the next PC is 0.
- Reset_n asserted mid-stream while in HOLD -> immediate PC=RESET_PC, Valid=0, IMemReq=0; normal fetch from RESET_PC after release.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID consumer.
package if_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_W    = XLEN;
  localparam int unsigned INSTR_W = XLEN;

  localparam logic [PC_W-1:0]    RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [PC_W-1:0]    pcplus4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  // Word fetched while decode was stalled, parked until the stall drops
  typedef struct packed {
    logic [PC_W-1:0]    pcplus4;
    logic [INSTR_W-1:0] instr;
  } skid_t;

  // Sequential PC increment, modulo 2^32
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear wins over load, otherwise holds.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t EMPTY = '{pcplus4: '0, instr: NOP_INSTR, valid: 1'b0};

  // Register update with flush (clear) taking priority over load
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= EMPTY;
    end else if (clear) begin
      q <= EMPTY;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM with one-entry skid buffer, IF/ID drive.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchTarget,
  output logic               IMemReq,
  output logic [PC_W-1:0]    IMemAddr,
  input  logic               IMemReady,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [PC_W-1:0]    PC,
  output logic [PC_W-1:0]    IF_ID_PCPlus4,
  output logic [INSTR_W-1:0] IF_ID_Instruction,
  output logic               IF_ID_Valid,
  output logic               FlushOut
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  skid_t           skid, skid_nxt;
  logic            ifid_load, ifid_clear;
  if_id_t          ifid_d, ifid_q;
  logic [PC_W-1:0] pc_plus4;

  // Target is word-aligned by construction; low bits are dropped
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^BranchTarget[1:0];

  assign pc_plus4 = pc_inc(pc);

  // State, PC and skid buffer registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      skid  <= skid_nxt;
    end
  end

  // Next-state, PC, skid and IF/ID control; a taken branch overrides everything
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    skid_nxt   = skid;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    ifid_d     = ifid_q;

    if (BranchTaken) begin
      pc_nxt     = {BranchTarget[PC_W-1:2], 2'b00};
      ifid_clear = 1'b1;
      skid_nxt   = '0;
      state_nxt  = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (IMemReady && !Stall) begin
            ifid_load = 1'b1;
            ifid_d    = '{pcplus4: pc_plus4, instr: IMemData, valid: 1'b1};
            pc_nxt    = pc_plus4;
          end else if (IMemReady && Stall) begin
            skid_nxt  = '{pcplus4: pc_plus4, instr: IMemData};
            pc_nxt    = pc_plus4;
            state_nxt = HOLD;
          end else if (!IMemReady && !Stall) begin
            // Bubble keeps the last PC+4 so decode sees a stable value
            ifid_load = 1'b1;
            ifid_d    = '{pcplus4: ifid_q.pcplus4, instr: NOP_INSTR, valid: 1'b0};
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifid_load = 1'b1;
            ifid_d    = '{pcplus4: skid.pcplus4, instr: skid.instr, valid: 1'b1};
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (ifid_load),
    .clear   (ifid_clear),
    .d       (ifid_d),
    .q       (ifid_q)
  );

  // Request and flush are combinational so the redirect lands on the same edge
  assign IMemReq           = (state == FETCH) & Reset_n;
  assign IMemAddr          = pc;
  assign FlushOut          = BranchTaken & Reset_n;
  assign PC                = pc;
  assign IF_ID_PCPlus4     = ifid_q.pcplus4;
  assign IF_ID_Instruction = ifid_q.instr;
  assign IF_ID_Valid       = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic against a queue-based model.
module tb_if_stage;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemData = '0;
  logic [31:0] PC;
  logic [31:0] IF_ID_PCPlus4;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        FlushOut;

  localparam logic [31:0] NOP = 32'h0000_0000;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: PC, IF/ID contents, and a queue of parked words
  logic [31:0] m_pc;
  logic [31:0] m_p4;
  logic [31:0] m_ins;
  logic        m_val;
  logic [63:0] m_park[$];

  if_stage dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .Stall             (Stall),
    .BranchTaken       (BranchTaken),
    .BranchTarget      (BranchTarget),
    .IMemReq           (IMemReq),
    .IMemAddr          (IMemAddr),
    .IMemReady         (IMemReady),
    .IMemData          (IMemData),
    .PC                (PC),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_Valid       (IF_ID_Valid),
    .FlushOut          (FlushOut)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_p4 = 32'h0; m_ins = NOP; m_val = 1'b0;
    m_park.delete();
  endtask

  task automatic check_regs();
    chk("pc",    PC,                m_pc);
    chk("p4",    IF_ID_PCPlus4,     m_p4);
    chk("instr", IF_ID_Instruction, m_ins);
    chk("valid", 32'(IF_ID_Valid),  32'(m_val));
  endtask

  // One clock: drive, check fetch-side outputs, advance, check registers
  task automatic cyc(input logic st, input logic rdy, input logic br,
                     input logic [31:0] tgt, input logic [31:0] dat);
    logic [63:0] w;
    Stall = st; IMemReady = rdy; BranchTaken = br; BranchTarget = tgt; IMemData = dat;
    #1;
    chk("req",   32'(IMemReq),  32'(m_park.size() == 0));
    chk("addr",  IMemAddr,      m_pc);
    chk("flush", 32'(FlushOut), 32'(br));
    @(posedge Clk); #1;
    if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_p4 = 32'h0; m_ins = NOP; m_val = 1'b0;
      m_park.delete();
    end else if (m_park.size() != 0) begin
      if (!st) begin
        w = m_park.pop_front();
        m_p4 = w[63:32]; m_ins = w[31:0]; m_val = 1'b1;
      end
    end else if (rdy) begin
      if (st) m_park.push_back({m_pc + 32'd4, dat});
      else begin
        m_p4 = m_pc + 32'd4; m_ins = dat; m_val = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_ins = NOP; m_val = 1'b0;
    end
    check_regs();
  endtask

  task automatic seq(input logic st, input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(st, rdy, 1'b0, 32'h0, word_at(m_pc));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_regs();
    chk("rst_req",   32'(IMemReq),  32'h0);
    chk("rst_flush", 32'(FlushOut), 32'h0);
    Reset_n = 1'b1;

    // Sequential stream 0,4
    seq(1'b0, 1'b1, 2);
    chk("seq_p4", IF_ID_PCPlus4, 32'd8);
    // Stall coinciding with ready at PC=8, held 3 cycles, then release
    seq(1'b1, 1'b1, 3);
    chk("stall_pc", PC, 32'd12);
    chk("stall_ins", IF_ID_Instruction, word_at(32'd4));
    seq(1'b0, 1'b1, 1);
    chk("rel_ins", IF_ID_Instruction, word_at(32'd8));
    seq(1'b0, 1'b1, 1);
    // Memory not ready for 2 cycles at PC=16
    seq(1'b0, 1'b0, 2);
    chk("bub_pc", PC, 32'd16);
    seq(1'b0, 1'b1, 2);
    // Branch while in HOLD with Stall high
    seq(1'b1, 1'b1, 1);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0103, 32'hDEAD_BEEF);
    chk("br_pc", PC, 32'h100);
    seq(1'b0, 1'b1, 3);
    // Wrap at top of address space
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0);
    seq(1'b0, 1'b1, 1);
    chk("wrap_p4", IF_ID_PCPlus4, 32'h0);
    chk("wrap_pc", PC, 32'h0);
    seq(1'b0, 1'b1, 2);
    // Asynchronous reset mid-cycle while in HOLD
    seq(1'b1, 1'b1, 2);
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h40;
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("arst_req",   32'(IMemReq),  32'h0);
    chk("arst_flush", 32'(FlushOut), 32'h0);
    BranchTaken = 1'b0; Stall = 1'b0;
    @(posedge Clk); #1;
    check_regs();
    Reset_n = 1'b1;
    seq(1'b0, 1'b1, 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, $urandom, $urandom);
    end
    seq(1'b0, 1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
